// File: rtl/csa_pkg.sv
// Shared types and default widths for the carry-select-adder sum accumulator.
package csa_pkg;

    localparam int unsigned SUM_W_DEF = 27;
    localparam int unsigned ACC_W_DEF = 30;
    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    // Clamp value used when saturation is enabled (default accumulator width).
    localparam logic [ACC_W_DEF-1:0] ACC_SAT = '1;

endpackage

// File: rtl/csa_sum_accumulator_if.sv
// Sample-in / result-out handshake bundle for csa_sum_accumulator.
interface csa_sum_accumulator_if
    import csa_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
);
    logic [SUM_W-1:0] sum_in;
    logic             in_valid;
    logic             in_ready;
    logic [LEN_W-1:0] frame_len;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;

    modport master (
        output sum_in, in_valid, frame_len, out_ready,
        input  in_ready, acc_out, out_valid, ovf
    );

    modport slave (
        input  sum_in, in_valid, frame_len, out_ready,
        output in_ready, acc_out, out_valid, ovf
    );
endinterface

// File: rtl/csa_sum_accumulator.sv
// Frame accumulator for a registered CSA sum; state updates on the falling clock edge.
// Define CSA_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module csa_sum_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned SUM_W = SUM_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    csa_sum_accumulator_if.slave  bus
);

    localparam int unsigned EXT_W = ACC_W + 1;
`ifdef CSA_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_VAL = '1;
`endif

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SUM_W-1:0] sum_c;
    logic             xfer_c;
    logic [EXT_W-1:0] sum_ext_c;
    logic [LEN_W-1:0] cnt_inc_c;
    logic             carry_c;

    assign sum_c     = bus.sum_in;
    assign xfer_c    = bus.in_valid && in_ready_q;
    assign sum_ext_c = EXT_W'(acc) + EXT_W'(sum_c);
    assign carry_c   = sum_ext_c[ACC_W];
    assign cnt_inc_c = cnt + LEN_W'(1);

    // Frame FSM with registered handshake outputs
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer_c) begin
                        acc   <= ACC_W'(sum_c);
                        cnt   <= '0;
                        len_q <= bus.frame_len;
                        ovf_q <= 1'b0;
                        if (bus.frame_len == '0) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (xfer_c) begin
`ifdef CSA_ACC_SATURATE_EN
                        // Once clamped, stay clamped for the rest of the frame
                        acc <= (carry_c || ovf_q) ? SAT_VAL : sum_ext_c[ACC_W-1:0];
`else
                        acc <= sum_ext_c[ACC_W-1:0];
`endif
                        ovf_q <= ovf_q | carry_c;
                        cnt   <= cnt_inc_c;
                        if (cnt_inc_c == len_q) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/csa_sum_accumulator.md
CSA_SUM_ACCUMULATOR -- requirements
Module: csa_sum_accumulator

Interface
REQ-001 Parameter SUM_W, default 27: width of the incoming registered carry-select-adder sum.
REQ-002 Parameter ACC_W, default 30: accumulator and result width.
REQ-003 Parameter LEN_W, default 4: width of the frame-length field.
REQ-004 Port `clk`, input, 1: single clock; all state updates on the falling edge of clk, matching the upstream sum register.
REQ-005 Port `reset`, input, 1: asynchronous, active-low reset.
REQ-006 Port `sum_in`, input, SUM_W: unsigned sum sample from the upstream registered adder stage.
REQ-007 Port `in_valid`, input, 1: sum_in holds a sample to consume.
REQ-008 Port `in_ready`, output, 1: block accepts sum_in on this edge.
REQ-009 Port `frame_len`, input, LEN_W: samples per frame minus one, so N = frame_len+1 (1..16); sampled only with the first sample of a frame.
REQ-010 Port `acc_out`, output, ACC_W: accumulated frame result.
REQ-011 Port `out_valid`, output, 1: acc_out and ovf are valid.
REQ-012 Port `out_ready`, input, 1: downstream takes the result.
REQ-013 Port `ovf`, output, 1: carry out of ACC_W occurred during the frame.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-015 A transfer SHALL occur on a falling edge when in_valid && in_ready.
REQ-016 In IDLE, in_ready SHALL be 1; a transfer SHALL load acc <= zero-extended sum_in, cnt <= 0, len_q <= frame_len, and ovf <= 0.
- From IDLE, the FSM SHALL go to DONE if frame_len == 0, otherwise to ACC.
REQ-017 In ACC, in_ready SHALL be 1; each transfer SHALL perform acc <= acc + sum_in and cnt <= cnt + 1.
- When the transfer with cnt+1 == len_q occurs, the FSM SHALL go to DONE.
REQ-018 When in_valid is low, the FSM SHALL hold state, acc and cnt unchanged.
REQ-019 In DONE, in_ready SHALL be 0 and out_valid SHALL be 1, with acc_out = acc.
- acc_out and ovf SHALL remain stable until out_ready is sampled high, at which point the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be one clock edge from the last transfer to out_valid=1. A new frame's first sample SHALL be accepted no earlier than the edge after the result handshake.
REQ-021 The addition SHALL be computed at ACC_W+1 bits. A carry-out SHALL set ovf, which stays sticky until the next frame load.
REQ-022 In IDLE and ACC, out_valid SHALL be 0. acc_out SHALL always reflect acc.
REQ-023 frame_len changes after the first sample SHALL have no effect on the current frame.
REQ-024 out_ready asserted outside DONE SHALL be ignored.

Reset
REQ-025 While reset=0, the following SHALL apply immediately, independent of clk: state=IDLE, acc=0, cnt=0, len_q=0, ovf=0, acc_out=0, out_valid=0, in_ready=1.
REQ-026 Reset asserted mid-frame or in DONE SHALL discard the partial or pending result; no output SHALL be produced for that frame.
REQ-027 The first transfer SHALL be possible on the first falling edge after reset deasserts.

Configuration
REQ-028 Macro CSA_ACC_SATURATE_EN SHALL select the overflow behaviour.
- Defined: on carry-out, acc SHALL clamp to all ones and remain there for the rest of the frame, with ovf=1.
- Undefined: acc SHALL wrap modulo 2^ACC_W, with ovf=1.

Structure
REQ-029 A shared package csa_pkg SHALL hold the following:
- SUM_W/ACC_W/LEN_W defaults;
- the state enumeration acc_state_t {IDLE, ACC, DONE};
- the all-ones saturation constant.
REQ-030 The design SHALL be a single module, with no sub-modules required. The adder SHALL be inline behavioural code.

Verification
REQ-031 Reset, then frame_len=3 and samples 1,2,3,4 on consecutive edges -> out_valid on the edge after the 4th sample, acc_out=10, ovf=0.
REQ-032 frame_len=0, sample 0x7FFFFFF -> DONE after one edge, acc_out=0x7FFFFFF; with out_ready held low 5 cycles -> acc_out stable and in_ready=0 throughout.
REQ-033 frame_len=15, 16 samples of 0x7FFFFFF, ACC_W=30 -> sum 0x7FFFFFF0 exceeds 2^30, so ovf=1.
- Without the macro: acc_out=0x3FFFFFF0.
- With CSA_ACC_SATURATE_EN: acc_out=0x3FFFFFFF.
REQ-034 frame_len=2, samples 5, gap (in_valid=0 for 3 cycles), 6, 7 -> acc_out=18, and the gap cycles do not advance cnt.
REQ-035 Reset pulled low asynchronously after 2 samples of a 4-sample frame -> out_valid=0 and acc_out=0 immediately; a new frame of samples 9,9 (frame_len=1) -> acc_out=18.
REQ-036 frame_len changed from 3 to 0 after the first sample -> the frame still consumes 4 samples.
